// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the unified memory port arbiter.
// Holds the FSM state enum, owner encoding and MEM_LAT legal range.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT,
        ARB_RESP
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    localparam int MEM_LAT_MIN = 1;
    localparam int MEM_LAT_MAX = 7;
    localparam int LAT_CW      = 3;

    // WAIT lasts lat-1 cycles and exits on the cycle the counter reads
    // zero, so the value loaded during ISSUE is lat-2.
    function automatic logic [LAT_CW-1:0] wait_load(input int lat);
        if (lat <= 2) return '0;
        return LAT_CW'(lat - 2);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, data and memory-port signals around the arbiter.
// slave: arbiter side; master: pipeline + memory side.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_ready;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_ready;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          stall_if;
    logic          stall_mem;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_rdata, if_ready, d_rdata, d_ready,
        output mem_en, mem_we, mem_addr, mem_wdata,
        output stall_if, stall_mem
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_rdata, if_ready, d_rdata, d_ready,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  stall_if, stall_mem
    );
endinterface

// File: rtl/mem_port_arbiter_lat_counter.sv
// Latency down-counter: load a value, decrement to zero, flag zero.
// Ports: clk, rst, load, load_val, dec, zero.
module lat_counter
    import mem_port_arbiter_pkg::*;
#(
    parameter int W = LAT_CW
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises IF fetches and MEM loads/stores onto one fixed-latency port.
// Ports: clk, rst, bus (mem_port_arbiter_if.slave), busy. Option: MEM_ARB_FAIR_EN.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    mem_port_arbiter_if.slave      bus,
    output logic                   busy
);

    // Out-of-range latencies are clamped to the legal window.
    localparam int LAT = (MEM_LAT < MEM_LAT_MIN) ? MEM_LAT_MIN :
                         (MEM_LAT > MEM_LAT_MAX) ? MEM_LAT_MAX : MEM_LAT;

    arb_state_t    state;
    arb_state_t    state_n;
    owner_t        owner_q;
    owner_t        grant;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic          we_q;
    logic          start;
    logic          cnt_zero;

`ifdef MEM_ARB_FAIR_EN
    logic          last_was_data;
`endif

    // Data is older in the pipeline, so it wins a tie unless the
    // fairness flag says data had the previous grant.
    always_comb begin
        grant = OWN_IF;
        if (bus.d_req) grant = OWN_D;
`ifdef MEM_ARB_FAIR_EN
        if (bus.d_req && bus.if_req && last_was_data) grant = OWN_IF;
`endif
    end

    assign start = (state == ARB_IDLE) && (bus.if_req || bus.d_req);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ARB_IDLE;
            owner_q <= OWN_IF;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
        end else begin
            state <= state_n;
            if (start) begin
                owner_q <= grant;
                addr_q  <= (grant == OWN_D) ? bus.d_addr : bus.if_addr;
                wdata_q <= (grant == OWN_D) ? bus.d_wdata : '0;
                we_q    <= (grant == OWN_D) && bus.d_we;
            end
        end
    end

`ifdef MEM_ARB_FAIR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_was_data <= 1'b0;
        end else if (start) begin
            last_was_data <= (grant == OWN_D);
        end
    end
`endif

    lat_counter #(.W(LAT_CW)) u_lat (
        .clk      (clk),
        .rst      (rst),
        .load     (state == ARB_ISSUE),
        .load_val (wait_load(LAT)),
        .dec      (state == ARB_WAIT),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_n       = state;
        bus.mem_en    = 1'b0;
        bus.if_ready  = 1'b0;
        bus.d_ready   = 1'b0;
        unique case (state)
            ARB_IDLE: begin
                if (start) state_n = ARB_ISSUE;
            end
            ARB_ISSUE: begin
                bus.mem_en = 1'b1;
                state_n    = (LAT == 1) ? ARB_RESP : ARB_WAIT;
            end
            ARB_WAIT: begin
                if (cnt_zero) state_n = ARB_RESP;
            end
            ARB_RESP: begin
                bus.if_ready = (owner_q == OWN_IF);
                bus.d_ready  = (owner_q == OWN_D);
                state_n      = ARB_IDLE;
            end
            default: state_n = ARB_IDLE;
        endcase
    end

    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_we    = we_q & bus.mem_en;
    assign bus.if_rdata  = bus.mem_rdata;
    assign bus.d_rdata   = bus.mem_rdata;
    assign bus.stall_if  = bus.if_req & ~bus.if_ready;
    assign bus.stall_mem = bus.d_req & ~bus.d_ready;
    assign busy          = (state != ARB_IDLE);

endmodule
